// File: rtl/bullet_layer_pkg.sv
// -----------------------------------------------------------------------------
// bullet_layer_pkg
// Shared display constants, bullet defaults, the bullet slot record, the
// bullet-layer FSM state type and its debug view.
//   H_DISP_LEN / V_DISP_LEN : coordinate widths of the display raster
//   COLOR_RGB_DEPTH         : RGB444 pixel width
//   BULLET_*_DEF            : defaults for the bullet_layer parameters
//   slot_t                  : one bullet slot {valid, x, y}, x/y = top-left
//   bl_state_t / bl_dbg_t   : FSM state and the debug snapshot on dbg_o
// -----------------------------------------------------------------------------
package bullet_layer_pkg;

   localparam int H_DISP_LEN      = 10;
   localparam int V_DISP_LEN      = 10;
   localparam int COLOR_RGB_DEPTH = 12;

   localparam logic [COLOR_RGB_DEPTH-1:0] COLOR_BULLET = 12'hFF0;

   localparam int BULLET_NUM_DEF   = 8;
   localparam int BULLET_W_DEF     = 4;
   localparam int BULLET_H_DEF     = 8;
   localparam int BULLET_SPEED_DEF = 4;
   localparam int SPAWN_X_OFS_DEF  = 14;
   localparam logic [COLOR_RGB_DEPTH-1:0] BULLET_COLOR_DEF = COLOR_BULLET;

   typedef struct packed {
      logic                  valid;
      logic [H_DISP_LEN-1:0] x;
      logic [V_DISP_LEN-1:0] y;
   } slot_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MOVE  = 2'd1,
      ST_SPAWN = 2'd2
   } bl_state_t;

   // idx is 4 bits wide so it covers the largest slot count (16).
   typedef struct packed {
      bl_state_t  state;
      logic [3:0] idx;
      logic       fire_pend;
   } bl_dbg_t;

endpackage

// File: rtl/bullet_layer_hit.sv
// -----------------------------------------------------------------------------
// bullet_hit
// Combinational hit test of one bullet slot against the requested pixel.
//   i_slot  : slot record {valid, x, y}
//   i_req_x : requested pixel x
//   i_req_y : requested pixel y
//   o_hit   : pixel lies inside the BULLET_W x BULLET_H box of a valid slot
// -----------------------------------------------------------------------------
module bullet_hit
   import bullet_layer_pkg::*;
#(
   parameter int BULLET_W = BULLET_W_DEF,
   parameter int BULLET_H = BULLET_H_DEF
)(
   input  slot_t                 i_slot,
   input  logic [H_DISP_LEN-1:0] i_req_x,
   input  logic [V_DISP_LEN-1:0] i_req_y,
   output logic                  o_hit
);

   // Right/bottom bounds are one bit wider so a bullet near the raster edge
   // cannot wrap around to zero.
   logic [H_DISP_LEN:0] w_x_end;
   logic [V_DISP_LEN:0] w_y_end;

   assign w_x_end = {1'b0, i_slot.x} + (H_DISP_LEN+1)'(BULLET_W);
   assign w_y_end = {1'b0, i_slot.y} + (V_DISP_LEN+1)'(BULLET_H);

   assign o_hit = i_slot.valid
                & (i_req_x >= i_slot.x) & ({1'b0, i_req_x} < w_x_end)
                & (i_req_y >= i_slot.y) & ({1'b0, i_req_y} < w_y_end);

endmodule

// File: rtl/bullet_layer.sv
// -----------------------------------------------------------------------------
// bullet_layer
// Pixel source for player bullets. Answers each pixel request one clk_vga
// cycle later with bullet colour/alpha, spawns a bullet above the plane on a
// fire pulse, and advances all bullets once per frame after v_sync falls.
//   clk_vga, rst          : pixel clock, async active-high reset
//   req_x_i/req_y_i/disp_i: pixel request and active-area flag
//   v_sync_i              : vertical sync (active-low), falling edge = update
//   fire_i                : one-cycle fire pulse
//   plane_x_i/plane_y_i   : plane top-left corner
//   bullet_rgb_o/alpha_o  : registered pixel answer
//   busy_o                : frame update (MOVE/SPAWN) in progress
//   active_cnt_o          : registered number of live bullets
//   dbg_o                 : FSM state, slot index and fire latch
// Protocol: there is no back-pressure. A request is presented for one cycle
// and its answer appears on the outputs exactly one cycle later; a fire pulse
// is captured whenever it occurs and consumed by the next SPAWN cycle.
// -----------------------------------------------------------------------------
module bullet_layer
   import bullet_layer_pkg::*;
#(
   parameter int BULLET_NUM   = BULLET_NUM_DEF,
   parameter int BULLET_W     = BULLET_W_DEF,
   parameter int BULLET_H     = BULLET_H_DEF,
   parameter int BULLET_SPEED = BULLET_SPEED_DEF,
   parameter int SPAWN_X_OFS  = SPAWN_X_OFS_DEF,
   parameter logic [COLOR_RGB_DEPTH-1:0] BULLET_COLOR = BULLET_COLOR_DEF
)(
   input  logic                         clk_vga,
   input  logic                         rst,
   input  logic [H_DISP_LEN-1:0]        req_x_i,
   input  logic [V_DISP_LEN-1:0]        req_y_i,
   input  logic                         disp_i,
   input  logic                         v_sync_i,
   input  logic                         fire_i,
   input  logic [H_DISP_LEN-1:0]        plane_x_i,
   input  logic [V_DISP_LEN-1:0]        plane_y_i,
   output logic [COLOR_RGB_DEPTH-1:0]   bullet_rgb_o,
   output logic                         bullet_alpha_o,
   output logic                         busy_o,
   output logic [$clog2(BULLET_NUM):0]  active_cnt_o,
   output bl_dbg_t                      dbg_o
);

   localparam int IDXW = $clog2(BULLET_NUM);
   localparam int CNTW = IDXW + 1;

   bl_state_t                   r_state;
   bl_state_t                   w_state_next;
   logic [IDXW-1:0]             r_idx;
   slot_t [BULLET_NUM-1:0]      r_slot;
   logic                        r_fire_pend;
   logic                        r_vs_d;
   logic                        r_alpha;
   logic [COLOR_RGB_DEPTH-1:0]  r_rgb;
   logic [CNTW-1:0]             r_cnt;

   logic [BULLET_NUM-1:0]       w_hit;
   logic                        w_any_hit;
   logic                        w_vs_fall;
   logic                        w_free_found;
   logic [IDXW-1:0]             w_free_idx;
   logic                        w_spawn_ok;
   slot_t                       w_new_slot;
   logic [CNTW-1:0]             w_cnt;

   // ---------------------------------------------------------------- hit test
   for (genvar g = 0; g < BULLET_NUM; g++) begin : g_hit
      bullet_hit #(
         .BULLET_W (BULLET_W),
         .BULLET_H (BULLET_H)
      ) u_hit (
         .i_slot  (r_slot[g]),
         .i_req_x (req_x_i),
         .i_req_y (req_y_i),
         .o_hit   (w_hit[g])
      );
   end

   assign w_any_hit = disp_i & (|w_hit);

   // ------------------------------------------------------- spawn candidate
   // Scan downwards so the last assignment wins: lowest free index.
   always_comb begin
      w_free_found = 1'b0;
      w_free_idx   = '0;
      for (int i = BULLET_NUM-1; i >= 0; i--) begin
         if (!r_slot[i].valid) begin
            w_free_found = 1'b1;
            w_free_idx   = IDXW'(i);
         end
      end
   end

   always_comb begin
      w_new_slot.valid = 1'b1;
      w_new_slot.x     = plane_x_i + H_DISP_LEN'(SPAWN_X_OFS);
      w_new_slot.y     = plane_y_i - V_DISP_LEN'(BULLET_H);
   end

   // A plane too close to the top would place the bullet above row 0.
   assign w_spawn_ok = r_fire_pend & w_free_found
                     & (plane_y_i >= V_DISP_LEN'(BULLET_H));

   // ---------------------------------------------------------------- FSM
   assign w_vs_fall = r_vs_d & ~v_sync_i;

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // A sync edge outside IDLE is ignored because only IDLE looks at it.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_vs_fall) w_state_next = ST_MOVE;
         ST_MOVE:  if (r_idx == IDXW'(BULLET_NUM-1)) w_state_next = ST_SPAWN;
         ST_SPAWN: w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // r_vs_d resets low so a v_sync already low at reset release is not an edge.
   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         r_vs_d <= 1'b0;
         r_idx  <= '0;
      end else begin
         r_vs_d <= v_sync_i;
         if (r_state == ST_IDLE && w_vs_fall) r_idx <= '0;
         else if (r_state == ST_MOVE)         r_idx <= r_idx + IDXW'(1);
      end
   end

   // ------------------------------------------------------------ fire latch
   // In SPAWN the latch takes fire_i directly, so a pulse landing in that
   // very cycle survives into the next frame.
   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst)                     r_fire_pend <= 1'b0;
      else if (r_state == ST_SPAWN) r_fire_pend <= fire_i;
      else if (fire_i)             r_fire_pend <= 1'b1;
   end

   // --------------------------------------------------------------- slots
   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         r_slot <= '0;
      end else begin
         case (r_state)
            ST_MOVE: begin
               if (r_slot[r_idx].valid) begin
                  if (r_slot[r_idx].y >= V_DISP_LEN'(BULLET_SPEED))
                     r_slot[r_idx].y <= r_slot[r_idx].y - V_DISP_LEN'(BULLET_SPEED);
                  else
                     r_slot[r_idx].valid <= 1'b0;
               end
            end
            ST_SPAWN: begin
               if (w_spawn_ok) r_slot[w_free_idx] <= w_new_slot;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------- outputs
   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < BULLET_NUM; i++) w_cnt = w_cnt + CNTW'(r_slot[i].valid);
   end

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         r_alpha <= 1'b0;
         r_rgb   <= '0;
         r_cnt   <= '0;
      end else begin
         r_alpha <= w_any_hit;
         r_rgb   <= w_any_hit ? BULLET_COLOR : '0;
         r_cnt   <= w_cnt;
      end
   end

   assign bullet_alpha_o  = r_alpha;
   assign bullet_rgb_o    = r_rgb;
   assign active_cnt_o    = r_cnt;
   assign busy_o          = (r_state != ST_IDLE);
   assign dbg_o.state     = r_state;
   assign dbg_o.idx       = 4'(r_idx);
   assign dbg_o.fire_pend = r_fire_pend;

endmodule

// File: tb/tb_bullet_layer.sv
// -----------------------------------------------------------------------------
// tb_bullet_layer
// Self-checking bench for bullet_layer with default parameters. A small
// reference model of the slots predicts every pixel answer, frame update and
// live count; pixel answers go through an expected queue.
// -----------------------------------------------------------------------------
module tb_bullet_layer;
   import bullet_layer_pkg::*;

   localparam int BN = 8;

   logic                        clk_vga;
   logic                        rst;
   logic [H_DISP_LEN-1:0]       req_x_i;
   logic [V_DISP_LEN-1:0]       req_y_i;
   logic                        disp_i;
   logic                        v_sync_i;
   logic                        fire_i;
   logic [H_DISP_LEN-1:0]       plane_x_i;
   logic [V_DISP_LEN-1:0]       plane_y_i;
   logic [COLOR_RGB_DEPTH-1:0]  bullet_rgb_o;
   logic                        bullet_alpha_o;
   logic                        busy_o;
   logic [3:0]                  active_cnt_o;
   bl_dbg_t                     dbg_o;

   bullet_layer dut (
      .clk_vga        (clk_vga),
      .rst            (rst),
      .req_x_i        (req_x_i),
      .req_y_i        (req_y_i),
      .disp_i         (disp_i),
      .v_sync_i       (v_sync_i),
      .fire_i         (fire_i),
      .plane_x_i      (plane_x_i),
      .plane_y_i      (plane_y_i),
      .bullet_rgb_o   (bullet_rgb_o),
      .bullet_alpha_o (bullet_alpha_o),
      .busy_o         (busy_o),
      .active_cnt_o   (active_cnt_o),
      .dbg_o          (dbg_o)
   );

   // ------------------------------------------------------ clock and reset
   initial begin
      clk_vga = 1'b0;
      forever #5 clk_vga = ~clk_vga;
   end

   // --------------------------------------------------------------- state
   int n_vec;
   int n_err;
   logic [12:0] exp_q[$];

   bit m_valid [BN];
   int m_x     [BN];
   int m_y     [BN];
   bit m_pend;

   task automatic tick();
      @(posedge clk_vga);
      #1;
   endtask

   // ----------------------------------------------------------- model
   function automatic bit m_hit(input int x, input int y);
      bit h;
      h = 1'b0;
      for (int i = 0; i < BN; i++)
         if (m_valid[i] && x >= m_x[i] && x < m_x[i] + 4 && y >= m_y[i] && y < m_y[i] + 8)
            h = 1'b1;
      return h;
   endfunction

   function automatic int m_count();
      int c;
      c = 0;
      for (int i = 0; i < BN; i++) c += int'(m_valid[i]);
      return c;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < BN; i++) begin
         m_valid[i] = 1'b0;
         m_x[i] = 0;
         m_y[i] = 0;
      end
      m_pend = 1'b0;
   endtask

   task automatic m_frame(input bit fire_in_spawn);
      bit done;
      for (int i = 0; i < BN; i++)
         if (m_valid[i]) begin
            if (m_y[i] >= 4) m_y[i] -= 4;
            else m_valid[i] = 1'b0;
         end
      done = 1'b0;
      if (m_pend && int'(plane_y_i) >= 8)
         for (int i = 0; i < BN; i++)
            if (!done && !m_valid[i]) begin
               m_valid[i] = 1'b1;
               m_x[i] = (int'(plane_x_i) + 14) % 1024;
               m_y[i] = int'(plane_y_i) - 8;
               done = 1'b1;
            end
      m_pend = fire_in_spawn;
   endtask

   // ---------------------------------------------------------- drivers
   task automatic do_reset();
      rst = 1'b1;
      fire_i = 1'b0;
      disp_i = 1'b0;
      v_sync_i = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      m_clear();
   endtask

   task automatic fire_pulse();
      fire_i = 1'b1;
      tick();
      fire_i = 1'b0;
      m_pend = 1'b1;
   endtask

   // One pixel request, back-to-back with the previous one when called in a loop.
   task automatic send_req(input int x, input int y, input bit d);
      logic [12:0] e;
      logic [12:0] got;
      req_x_i = 10'(x);
      req_y_i = 10'(y);
      disp_i  = d;
      exp_q.push_back((d && m_hit(x, y)) ? {1'b1, 12'hFF0} : 13'd0);
      tick();
      got = {bullet_alpha_o, bullet_rgb_o};
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
         n_err++;
         $display("FAIL pixel x=%0d y=%0d disp=%0d: got %h expected %h", x, y, d, got, e);
      end
   endtask

   task automatic sweep_rect(input int x0, input int x1, input int y0, input int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            send_req(x, y, 1'b1);
      disp_i = 1'b0;
   endtask

   // Drives one v_sync fall and checks the whole update against the model.
   task automatic do_frame(input bit fire_in_spawn, input bit refall);
      int busy_n;
      int guard;
      v_sync_i = 1'b1;
      tick();
      v_sync_i = 1'b0;
      tick();
      busy_n = 0;
      guard = 0;
      while (busy_o && guard < 40) begin
         busy_n++;
         if (refall && busy_n == 2) v_sync_i = 1'b1;
         if (refall && busy_n == 3) v_sync_i = 1'b0;
         if (fire_in_spawn && busy_n == 9) fire_i = 1'b1;
         tick();
         fire_i = 1'b0;
         guard++;
      end
      m_frame(fire_in_spawn);
      n_vec++;
      if (busy_n != 9) begin
         n_err++;
         $display("FAIL busy_len: got %0d cycles expected 9", busy_n);
      end
      v_sync_i = 1'b1;
      tick();
      n_vec++;
      if (active_cnt_o !== 4'(m_count())) begin
         n_err++;
         $display("FAIL active_cnt: got %0d expected %0d", active_cnt_o, m_count());
      end
      n_vec++;
      if (dbg_o.fire_pend !== m_pend || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL post_frame: got pend=%0d busy=%0d expected pend=%0d busy=0",
                  dbg_o.fire_pend, busy_o, m_pend);
      end
   endtask

   // ------------------------------------------------------------- tests
   task automatic test_reset();
      rst = 1'b1;
      fire_i = 1'b0;
      disp_i = 1'b0;
      v_sync_i = 1'b1;
      req_x_i = '0;
      req_y_i = '0;
      plane_x_i = '0;
      plane_y_i = '0;
      repeat (3) tick();
      rst = 1'b0;
      m_clear();
      tick();
      n_vec++;
      if ({bullet_alpha_o, bullet_rgb_o} !== 13'd0) begin
         n_err++;
         $display("FAIL reset_pixel: got %h expected 0", {bullet_alpha_o, bullet_rgb_o});
      end
      n_vec++;
      if (busy_o !== 1'b0 || active_cnt_o !== 4'd0) begin
         n_err++;
         $display("FAIL reset_status: got busy=%0d cnt=%0d expected 0 0", busy_o, active_cnt_o);
      end
      n_vec++;
      if (dbg_o.state !== ST_IDLE || dbg_o.fire_pend !== 1'b0) begin
         n_err++;
         $display("FAIL reset_fsm: got state=%0d pend=%0d expected IDLE 0", dbg_o.state, dbg_o.fire_pend);
      end
      for (int k = 0; k < 1500; k++)
         send_req(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1);
      disp_i = 1'b0;
   endtask

   task automatic test_single_spawn();
      do_reset();
      plane_x_i = 10'd300;
      plane_y_i = 10'd400;
      fire_pulse();
      do_frame(1'b0, 1'b0);
      n_vec++;
      if (active_cnt_o !== 4'd1) begin
         n_err++;
         $display("FAIL spawn_cnt: got %0d expected 1", active_cnt_o);
      end
      sweep_rect(310, 321, 388, 403);
      // Same bullet pixels with disp low must stay transparent.
      for (int x = 314; x <= 317; x++) send_req(x, 395, 1'b0);
      for (int k = 0; k < 300; k++)
         send_req(int'($urandom_range(300, 330)), int'($urandom_range(380, 410)),
                  1'($urandom_range(0, 1)));
      disp_i = 1'b0;
   endtask

   task automatic test_move_exit();
      do_reset();
      plane_x_i = 10'd100;
      plane_y_i = 10'd14;
      fire_pulse();
      do_frame(1'b0, 1'b0);
      sweep_rect(110, 121, 0, 16);
      do_frame(1'b0, 1'b0);
      n_vec++;
      if (active_cnt_o !== 4'd1) begin
         n_err++;
         $display("FAIL move_cnt: got %0d expected 1", active_cnt_o);
      end
      sweep_rect(110, 121, 0, 12);
      do_frame(1'b0, 1'b0);
      n_vec++;
      if (active_cnt_o !== 4'd0) begin
         n_err++;
         $display("FAIL exit_cnt: got %0d expected 0", active_cnt_o);
      end
      // Plane too high: the fire is dropped and the latch still clears.
      plane_y_i = 10'd7;
      fire_pulse();
      do_frame(1'b0, 1'b0);
      plane_y_i = 10'd200;
      do_frame(1'b0, 1'b0);
      n_vec++;
      if (active_cnt_o !== 4'd0) begin
         n_err++;
         $display("FAIL drop_high_cnt: got %0d expected 0", active_cnt_o);
      end
   endtask

   task automatic test_full_slots();
      do_reset();
      plane_x_i = 10'd50;
      plane_y_i = 10'd400;
      for (int f = 0; f < 9; f++) begin
         fire_pulse();
         do_frame(1'b0, 1'b0);
      end
      n_vec++;
      if (active_cnt_o !== 4'd8 || dbg_o.fire_pend !== 1'b0) begin
         n_err++;
         $display("FAIL full_slots: got cnt=%0d pend=%0d expected 8 0", active_cnt_o, dbg_o.fire_pend);
      end
      sweep_rect(62, 69, 350, 360);
   endtask

   task automatic test_simultaneous();
      do_reset();
      plane_x_i = 10'd200;
      plane_y_i = 10'd300;
      do_frame(1'b1, 1'b1);
      n_vec++;
      if (active_cnt_o !== 4'd0 || dbg_o.fire_pend !== 1'b1) begin
         n_err++;
         $display("FAIL spawn_cycle_fire: got cnt=%0d pend=%0d expected 0 1", active_cnt_o, dbg_o.fire_pend);
      end
      do_frame(1'b0, 1'b0);
      n_vec++;
      if (active_cnt_o !== 4'd1) begin
         n_err++;
         $display("FAIL late_spawn_cnt: got %0d expected 1", active_cnt_o);
      end
      sweep_rect(212, 219, 290, 294);
   endtask

   task automatic test_mid_reset();
      int guard;
      do_reset();
      plane_x_i = 10'd400;
      plane_y_i = 10'd250;
      fire_pulse();
      do_frame(1'b0, 1'b0);
      fire_pulse();
      do_frame(1'b0, 1'b0);
      v_sync_i = 1'b0;
      guard = 0;
      while (!(dbg_o.state == ST_MOVE && dbg_o.idx == 4'd3) && guard < 20) begin
         tick();
         guard++;
      end
      n_vec++;
      if (guard >= 20) begin
         n_err++;
         $display("FAIL reach_idx3: got state=%0d idx=%0d expected MOVE 3", dbg_o.state, dbg_o.idx);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if (dbg_o.state !== ST_IDLE || busy_o !== 1'b0 || {bullet_alpha_o, bullet_rgb_o} !== 13'd0) begin
         n_err++;
         $display("FAIL mid_reset_now: got state=%0d busy=%0d pix=%h expected IDLE 0 0",
                  dbg_o.state, busy_o, {bullet_alpha_o, bullet_rgb_o});
      end
      tick();
      rst = 1'b0;
      m_clear();
      tick();
      n_vec++;
      if (active_cnt_o !== 4'd0 || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_after: got cnt=%0d busy=%0d expected 0 0", active_cnt_o, busy_o);
      end
      sweep_rect(412, 419, 226, 242);
      fire_pulse();
      do_frame(1'b0, 1'b0);
      sweep_rect(412, 419, 238, 244);
   endtask

   // ------------------------------------------------------------- main
   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_single_spawn();
      test_move_exit();
      test_full_slots();
      test_simultaneous();
      test_mid_reset();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bullet_layer.md
# bullet_layer

Pixel-source layer that answers display-controller pixel requests with bullet colour and alpha. It owns up to `BULLET_NUM` bullet slots, spawns a bullet at the player plane on each fire pulse, and advances every bullet once per frame during vertical blanking. It sits beside the player-plane sprite source and feeds the controller's `bullet_rgb_i` / `bullet_alpha_i` inputs. The controller gives bullets priority over the plane.

## Interface
Parameters:
- `BULLET_NUM`, 8: number of slots; power of two, 2..16.
- `BULLET_W`, 4: bullet width in pixels.
- `BULLET_H`, 8: bullet height in pixels.
- `BULLET_SPEED`, 4: upward move per frame, in pixels.
- `SPAWN_X_OFS`, 14: x offset from the plane's top-left corner to the bullet's left edge.
- `BULLET_COLOR`, 12'hFF0: RGB444 colour of every bullet.

Ports:
- `clk_vga` in 1: pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_x_i` in `H_DISP_LEN`: requested pixel x.
- `req_y_i` in `V_DISP_LEN`: requested pixel y.
- `disp_i` in 1: request lies in the active area.
- `v_sync_i` in 1: vertical sync, active-low.
- `fire_i` in 1: one-cycle fire pulse, already synchronous to `clk_vga`.
- `plane_x_i` in `H_DISP_LEN`: plane top-left x.
- `plane_y_i` in `V_DISP_LEN`: plane top-left y.
- `bullet_rgb_o` out `COLOR_RGB_DEPTH`: pixel colour.
- `bullet_alpha_o` out 1: pixel is covered by a bullet.
- `busy_o` out 1: frame update in progress.
- `active_cnt_o` out `$clog2(BULLET_NUM)+1`: number of live bullets.

## Operation
- Each slot holds `valid`, `x` (`H_DISP_LEN` bits) and `y` (`V_DISP_LEN` bits); `x` and `y` are the bullet's top-left corner.
- Hit test:
  - Slot i hits when `valid`, `x <= req_x < x+BULLET_W` and `y <= req_y < y+BULLET_H`.
  - Sums are computed one bit wider than the operand, so there is no wrap.
  - Hits from all slots are OR-reduced.
  - When `disp_i` is low, the layer reports no hit.
- `bullet_rgb_o` = `BULLET_COLOR` on a hit, otherwise 0.
- Fire latch:
  - `fire_i` sets `fire_pend`.
  - `fire_pend` clears only in the SPAWN state.
  - Multiple pulses within one frame collapse into one spawn.
- FSM:
  - IDLE: on the falling edge of `v_sync_i` (registered previous value 1, current 0), set slot index to 0 and go to MOVE.
  - MOVE, one slot per cycle:
    - If `valid` and `y >= BULLET_SPEED`: `y <= y - BULLET_SPEED`.
    - If `valid` and `y < BULLET_SPEED`: `valid <= 0`.
    - Empty slots are left unchanged.
    - After slot `BULLET_NUM-1`, go to SPAWN.
  - SPAWN, one cycle:
    - If `fire_pend` and `plane_y_i >= BULLET_H` and a free slot exists: the lowest-index free slot gets `valid=1`, `x = plane_x_i + SPAWN_X_OFS` truncated to `H_DISP_LEN`, `y = plane_y_i - BULLET_H`.
    - `fire_pend` clears in this state whether or not a bullet spawned; a fire that finds no free slot, or `plane_y_i < BULLET_H`, is dropped.
    - Go to IDLE.
- `busy_o` = state is MOVE or SPAWN.
- Slots change only in MOVE and SPAWN, and both complete inside vertical blanking, so a frame is never drawn from partly updated slots.
- `active_cnt_o` is a registered popcount of the `valid` bits.

## Timing
- Reset values: all slots invalid, `fire_pend` 0, FSM in IDLE, `bullet_rgb_o` 0, `bullet_alpha_o` 0, `busy_o` 0, `active_cnt_o` 0.
- Pixel response latency is exactly 1 `clk_vga` cycle: the outputs registered at edge n+1 answer the request presented at edge n. The address generator issues requests one cycle ahead to compensate.
- The frame update takes `BULLET_NUM`+1 cycles. It starts 1 cycle after `v_sync_i` falls.
- `fire_i` in the same cycle as SPAWN: the pulse is not lost. `fire_pend` is re-set and spawns in the next frame.
- A `v_sync_i` falling edge while `busy_o` is high is ignored.
- `active_cnt_o` lags a slot change by 1 cycle.
- Reset asserted mid-update returns the block to the reset state immediately; the next update starts on the next sync edge.

## Structure
- `BULLET_*` defaults and the slot record layout go into `define.v`, next to the `COLOR_*` and `DISP_LEN` constants. `BULLET_COLOR` defaults to the shared bullet colour macro.
- Natural sub-module: `bullet_hit`. It is purely combinational: one slot's registers and the requested x/y in, a hit bit out. It is generated `BULLET_NUM` times.
- The FSM, the fire latch and the output registers are in the top module.

## Test plan
- Reset: hold `rst` for 3 cycles → all outputs 0, `busy_o` 0; a request sweep over the full frame shows no alpha.
- Single spawn:
  - Stimulus: `plane_x_i`=300, `plane_y_i`=400, one `fire_i` pulse, then a `v_sync_i` fall.
  - Response: `busy_o` is high for 9 cycles and `active_cnt_o` becomes 1.
  - In the next frame, alpha is 1 exactly for x 314..317, y 392..399, with rgb 12'hFF0; latency is 1 cycle.
- Movement and exit:
  - Stimulus: a bullet spawned at y=6, then a `v_sync_i` fall.
  - Response: next frame y=2; on the following frame the bullet is invalidated and `active_cnt_o` returns to 0.
- Full slots: fire in 9 consecutive frames with no bullet leaving → `active_cnt_o` saturates at 8 and the 9th fire is dropped with `fire_pend` cleared.
- Simultaneous events: `fire_i` in the SPAWN cycle → it spawns one frame later; a `v_sync_i` fall during MOVE is ignored.
- Mid-update reset: `rst` asserted during MOVE with slot index 3 → all slots invalid and the FSM in IDLE on the next cycle.
